// File: rtl/async_fifo_pkg.sv
// ============================================================================
// Module : async_fifo_pkg
// Brief  : Shared async-FIFO sizing constants and Gray/binary conversions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package async_fifo_pkg;

  localparam int ADDR_W = 6;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin.sv
// ============================================================================
// Module : gray2bin
// Brief  : Width-generic Gray-to-binary converter (purely combinational).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gray2bin #(
  parameter int W = 7
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Each binary bit is the parity of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/r_ptr_ctrl.sv
// ============================================================================
// Module : r_ptr_ctrl
// Brief  : Async-FIFO read-side pointer controller (r_clk domain). Define
//          R_PTR_LEVEL_EN to build the fill-level / almost-empty logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module r_ptr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int AEMPTY_TH = 4
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_en,
  input  logic [ADDR_W:0]   w_ptr_g_sync,
  output logic              r_empty,
  output logic [ADDR_W:0]   r_ptr_g,
  output logic [ADDR_W-1:0] r_addr,
  output logic              r_valid,
  output logic              r_udf,
  output logic [ADDR_W:0]   r_level,
  output logic              r_aempty
);

  localparam int c_PTR_W = ADDR_W + 1;

  logic [ADDR_W:0] r_ptr_b;
  logic [ADDR_W:0] w_ptr_b_nxt;
  logic [ADDR_W:0] w_ptr_g_nxt;
  logic [ADDR_W:0] w_ptr_b_sync;
  logic            w_rd_acc;

  gray2bin #(.W(c_PTR_W)) u_w_ptr_g2b (
    .i_gray (w_ptr_g_sync),
    .o_bin  (w_ptr_b_sync)
  );

  assign w_rd_acc    = r_en & ~r_empty;
  assign w_ptr_b_nxt = r_ptr_b + {{ADDR_W{1'b0}}, w_rd_acc};
  // Gray is derived from the next pointer so the exported register flips one bit per edge.
  assign w_ptr_g_nxt = w_ptr_b_nxt ^ (w_ptr_b_nxt >> 1);
  assign r_addr      = r_ptr_b[ADDR_W-1:0];

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_ptr_b <= '0;
      r_ptr_g <= '0;
      r_empty <= 1'b1;
      r_valid <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_ptr_b <= w_ptr_b_nxt;
      r_ptr_g <= w_ptr_g_nxt;
      r_empty <= (w_ptr_b_sync == w_ptr_b_nxt);
      r_valid <= w_rd_acc;
      r_udf   <= r_en & r_empty;
    end
  end

`ifdef R_PTR_LEVEL_EN
  localparam logic [ADDR_W:0] c_AEMPTY_TH = c_PTR_W'(AEMPTY_TH);

  logic [ADDR_W:0] w_level_nxt;

  assign w_level_nxt = w_ptr_b_sync - w_ptr_b_nxt;

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_level  <= '0;
      r_aempty <= 1'b1;
    end else begin
      r_level  <= w_level_nxt;
      r_aempty <= (w_level_nxt <= c_AEMPTY_TH);
    end
  end
`else
  assign r_level  = '0;
  assign r_aempty = r_empty;
`endif

endmodule

`default_nettype wire

// File: tb/tb_r_ptr_ctrl.sv
// ============================================================================
// Module : tb_r_ptr_ctrl
// Brief  : Directed self-checking bench for r_ptr_ctrl (vector table + sequences).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_r_ptr_ctrl;
  import async_fifo_pkg::*;

  logic       r_clk = 1'b0;
  logic       r_rst;
  logic       r_en;
  logic [6:0] w_ptr_g_sync;
  logic       r_empty;
  logic [6:0] r_ptr_g;
  logic [5:0] r_addr;
  logic       r_valid;
  logic       r_udf;
  logic [6:0] r_level;
  logic       r_aempty;

  int checks = 0;
  int errors = 0;

  r_ptr_ctrl #(.ADDR_W(6), .AEMPTY_TH(4)) dut (
    .r_clk        (r_clk),
    .r_rst        (r_rst),
    .r_en         (r_en),
    .w_ptr_g_sync (w_ptr_g_sync),
    .r_empty      (r_empty),
    .r_ptr_g      (r_ptr_g),
    .r_addr       (r_addr),
    .r_valid      (r_valid),
    .r_udf        (r_udf),
    .r_level      (r_level),
    .r_aempty     (r_aempty)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    logic [6:0] wg;
    logic       en;
    logic       e_empty;
    logic       e_valid;
    logic       e_udf;
    logic [5:0] e_addr;
    logic [6:0] e_g;
    logic [6:0] e_lvl;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_empty, input logic e_valid,
                         input logic e_udf, input logic [5:0] e_addr,
                         input logic [6:0] e_g, input logic [6:0] e_lvl);
    chk({tag, ".empty"}, 32'(r_empty), 32'(e_empty));
    chk({tag, ".valid"}, 32'(r_valid), 32'(e_valid));
    chk({tag, ".udf"},   32'(r_udf),   32'(e_udf));
    chk({tag, ".addr"},  32'(r_addr),  32'(e_addr));
    chk({tag, ".ptr_g"}, 32'(r_ptr_g), 32'(e_g));
`ifdef R_PTR_LEVEL_EN
    chk({tag, ".level"},  32'(r_level),  32'(e_lvl));
    chk({tag, ".aempty"}, 32'(r_aempty), 32'(e_lvl <= 7'd4));
`else
    chk({tag, ".level"},  32'(r_level),  32'd0);
    chk({tag, ".aempty"}, 32'(r_aempty), 32'(e_empty));
`endif
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  initial begin
    int nvalid;

    //         wg     en    empty valid udf   addr   g      lvl
    tbl[0] = '{7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 7'h00, 7'd0};
    tbl[1] = '{7'h00, 1'b1, 1'b1, 1'b0, 1'b1, 6'd0, 7'h00, 7'd0};
    tbl[2] = '{7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 7'h00, 7'd0};
    tbl[3] = '{7'h02, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 7'h00, 7'd3};
    tbl[4] = '{7'h02, 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 7'h01, 7'd2};
    tbl[5] = '{7'h02, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2, 7'h03, 7'd1};
    tbl[6] = '{7'h02, 1'b1, 1'b1, 1'b1, 1'b0, 6'd3, 7'h02, 7'd0};
    tbl[7] = '{7'h02, 1'b1, 1'b1, 1'b0, 1'b1, 6'd3, 7'h02, 7'd0};
    tbl[8] = '{7'h02, 1'b1, 1'b1, 1'b0, 1'b1, 6'd3, 7'h02, 7'd0};
    tbl[9] = '{7'h02, 1'b0, 1'b1, 1'b0, 1'b0, 6'd3, 7'h02, 7'd0};

    r_rst        = 1'b1;
    r_en         = 1'b0;
    w_ptr_g_sync = 7'h00;
    #12;
    chk_all("reset", 1'b1, 1'b0, 1'b0, 6'd0, 7'h00, 7'd0);
    @(posedge r_clk);
    #1;
    r_rst = 1'b0;

    // Idle underflow, then three entries drained by a held r_en.
    for (int i = 0; i < 10; i++) begin
      w_ptr_g_sync = tbl[i].wg;
      r_en         = tbl[i].en;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_empty, tbl[i].e_valid, tbl[i].e_udf,
              tbl[i].e_addr, tbl[i].e_g, tbl[i].e_lvl);
    end

    // Writer reaches pointer 64; drain from 3 to 64.
    w_ptr_g_sync = bin2gray(7'd64);
    r_en         = 1'b0;
    tick();
    chk_all("fill64", 1'b0, 1'b0, 1'b0, 6'd3, 7'h02, 7'd61);
    r_en   = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 61; i++) begin
      tick();
      if (r_valid) nvalid++;
    end
    chk("drain64.valid_count", 32'(nvalid), 32'd61);
    chk("drain64.ptr_g", 32'(r_ptr_g), 32'h60);
    chk("drain64.addr", 32'(r_addr), 32'd0);
    chk("drain64.empty", 32'(r_empty), 32'd1);

    // 64 more writes wrap the writer to 0; reading them wraps the reader too.
    r_en         = 1'b0;
    w_ptr_g_sync = 7'h00;
    tick();
    chk_all("fill128", 1'b0, 1'b0, 1'b0, 6'd0, 7'h60, 7'd64);
    r_en = 1'b1;
    tick();
    chk_all("wrap_first", 1'b0, 1'b1, 1'b0, 6'd1, 7'h61, 7'd63);
    nvalid = 1;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (r_valid) nvalid++;
    end
    chk("wrap.valid_count", 32'(nvalid), 32'd64);
    chk_all("wrap_end", 1'b1, 1'b1, 1'b0, 6'd0, 7'h00, 7'd0);
    r_en = 1'b0;
    tick();

    // Write and read land in the same cycle.
    w_ptr_g_sync = bin2gray(7'd1);
    tick();
    chk_all("same_pre", 1'b0, 1'b0, 1'b0, 6'd0, 7'h00, 7'd1);
    w_ptr_g_sync = bin2gray(7'd2);
    r_en         = 1'b1;
    tick();
    chk_all("same_rw", 1'b0, 1'b1, 1'b0, 6'd1, 7'h01, 7'd1);
    r_en = 1'b0;
    tick();
    chk_all("same_post", 1'b0, 1'b0, 1'b0, 6'd1, 7'h01, 7'd1);

    // Level steps down through the almost-empty threshold.
    w_ptr_g_sync = bin2gray(7'd8);
    tick();
    chk_all("th7", 1'b0, 1'b0, 1'b0, 6'd1, 7'h01, 7'd7);
    r_en = 1'b1;
    tick();
    chk_all("th6", 1'b0, 1'b1, 1'b0, 6'd2, 7'h03, 7'd6);
    tick();
    chk_all("th5", 1'b0, 1'b1, 1'b0, 6'd3, 7'h02, 7'd5);
    tick();
    chk_all("th4", 1'b0, 1'b1, 1'b0, 6'd4, 7'h06, 7'd4);
    tick();
    chk_all("burst", 1'b0, 1'b1, 1'b0, 6'd5, 7'h07, 7'd3);

    // Asynchronous reset mid-burst with r_en still high.
    #2;
    r_rst = 1'b1;
    #1;
    chk_all("arst_now", 1'b1, 1'b0, 1'b0, 6'd0, 7'h00, 7'd0);
    tick();
    chk_all("arst_edge", 1'b1, 1'b0, 1'b0, 6'd0, 7'h00, 7'd0);
    r_rst = 1'b0;
    tick();
    chk_all("post_rst1", 1'b0, 1'b0, 1'b1, 6'd0, 7'h00, 7'd8);
    tick();
    chk_all("post_rst2", 1'b0, 1'b1, 1'b0, 6'd1, 7'h01, 7'd7);
    r_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
